sseg_display_driver: RTL and testbench

SSEG_DISPLAY_DRIVER -- requirements
Module: sseg_display_driver

---
 rtl/sseg_display_driver.sv | 166 ++++++++++++++++
 tb/tb_sseg_display_driver.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_display_driver.sv
// Eight-digit multiplexed seven-segment driver with hex display and a
// serial double-dabble binary-to-BCD converter for decimal display.
module sseg_display_driver #(
  parameter int N_DIGITS    = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         value,
  input  logic                load,
  input  logic                dec,
  input  logic                blank_lz,
  output logic [6:0]          segments,
  output logic [N_DIGITS-1:0] anodes,
  output logic                busy,
  output logic                overflow,
  output logic [1:0]          dbg_state
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int SW = $clog2(N_DIGITS);
  localparam logic [CW-1:0] PRE_MAX = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic [31:0]             bin_q;
  logic [39:0]             bcd_q;
  logic [38:0]             bcd_adj;
  logic [4:0]              iter_q;
  logic [4*N_DIGITS-1:0]   digits_q;
  logic                    ovf_q;
  logic                    accept;
  logic [CW-1:0]           pre_q;
  logic [SW-1:0]           scan_q;
  logic [SW-1:0]           msd;
  logic [3:0]              cur_digit;
  logic                    blank;
  logic [6:0]              seg_nxt;
  logic [N_DIGITS-1:0]     an_nxt;

  // Load handshake: load is taken on any edge where busy is low (including
  // the COMMIT cycle); a load seen while busy is high is dropped, not queued.
  assign accept    = load && (state != CONVERT);
  assign busy      = (state == CONVERT);
  assign overflow  = ovf_q;
  assign dbg_state = state;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    case (d)
      4'h0:    return 7'h40;
      4'h1:    return 7'h79;
      4'h2:    return 7'h24;
      4'h3:    return 7'h30;
      4'h4:    return 7'h19;
      4'h5:    return 7'h12;
      4'h6:    return 7'h02;
      4'h7:    return 7'h78;
      4'h8:    return 7'h00;
      4'h9:    return 7'h10;
      4'hA:    return 7'h08;
      4'hB:    return 7'h03;
      4'hC:    return 7'h46;
      4'hD:    return 7'h21;
      4'hE:    return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  // The top BCD digit of a 32-bit value never reaches 5, so it needs no add-3.
  always_comb begin
    bcd_adj = bcd_q[38:0];
    for (int i = 0; i < 9; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, COMMIT: begin
        if (accept) state_nxt = dec ? CONVERT : COMMIT;
        else        state_nxt = IDLE;
      end
      CONVERT: begin
        if (iter_q == 5'd31) state_nxt = COMMIT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Hex loads reuse the COMMIT path so both modes publish through one place.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      bin_q    <= '0;
      bcd_q    <= '0;
      iter_q   <= '0;
      digits_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == COMMIT) begin
        digits_q <= bcd_q[4*N_DIGITS-1:0];
        ovf_q    <= |bcd_q[39:32];
      end
      if (accept) begin
        iter_q <= '0;
        if (dec) begin
          bin_q <= value;
          bcd_q <= '0;
        end else begin
          bcd_q <= {8'h00, value};
        end
      end else if (state == CONVERT) begin
        {bcd_q, bin_q} <= {bcd_adj, bin_q, 1'b0};
        iter_q         <= iter_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q  <= '0;
      scan_q <= '0;
    end else if (pre_q == PRE_MAX) begin
      pre_q  <= '0;
      scan_q <= scan_q + SW'(1);
    end else begin
      pre_q <= pre_q + CW'(1);
    end
  end

  always_comb begin
    msd = '0;
    for (int i = 1; i < N_DIGITS; i++) begin
      if (digits_q[4*i +: 4] != 4'd0) msd = SW'(i);
    end
  end

  always_comb begin
    cur_digit = digits_q[{scan_q, 2'b00} +: 4];
    blank     = blank_lz && !ovf_q && (scan_q > msd);
    seg_nxt   = ovf_q ? 7'h3F : seg_encode(cur_digit);
    an_nxt    = ~(N_DIGITS'(1) << scan_q);
    if (blank) begin
      seg_nxt = 7'h7F;
      an_nxt  = '1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      segments <= 7'h7F;
      anodes   <= '1;
    end else begin
      segments <= seg_nxt;
      anodes   <= an_nxt;
    end
  end

endmodule

// File: tb/tb_sseg_display_driver.sv
// Bench for sseg_display_driver: event-level model feeding an expected queue,
// per-cycle output comparison, plus literal scan checks of known values.
module tb_sseg_display_driver;

  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] value;
  logic        load, dec, blank_lz;
  logic [6:0]  segments;
  logic [7:0]  anodes;
  logic        busy, overflow;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [16:0] exp_q[$];
  logic [6:0]  seg_lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [6:0]  hex_exp [8] = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h19, 7'h30, 7'h24, 7'h79};
  logic [6:0]  dec_exp [8] = '{7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
  logic [6:0]  dash_exp[8] = '{7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
  logic [6:0]  zero_exp[8] = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  logic [3:0]  m_dig[8], p_dig[8];
  bit          m_ovf, p_ovf;
  int          m_rem, m_cyc;

  logic [6:0]  cap_seg[8];
  int          cap_seen[8];
  bit          cap_busy;

  sseg_display_driver #(.N_DIGITS(8), .REFRESH_DIV(RD)) dut (
    .clk(clk), .reset(reset), .value(value), .load(load), .dec(dec),
    .blank_lz(blank_lz), .segments(segments), .anodes(anodes),
    .busy(busy), .overflow(overflow), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_cyc = 0;
    m_rem = 0;
    m_ovf = 0;
    p_ovf = 0;
    for (int i = 0; i < 8; i++) begin
      m_dig[i] = 4'd0;
      p_dig[i] = 4'd0;
    end
  endtask

  // Model: digit i of the display, scan slot = (cycles since reset / RD) % 8,
  // decimal digits from plain division, commit 33 edges (decimal) or 1 edge
  // (hex) after an accepted load.
  task automatic model_loop();
    int idx, msd;
    logic [7:0] an;
    logic [6:0] sg;
    bit acc;
    longint unsigned v, pw;
    model_clear();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        model_clear();
      end else begin
        idx = (m_cyc / RD) % 8;
        msd = 0;
        for (int i = 1; i < 8; i++) if (m_dig[i] != 4'd0) msd = i;
        an = 8'hFF;
        sg = 7'h7F;
        if (m_ovf) begin
          an[idx] = 1'b0;
          sg = 7'h3F;
        end else if (!(blank_lz && idx > msd)) begin
          an[idx] = 1'b0;
          sg = seg_lut[m_dig[idx]];
        end
        acc = load && (m_rem < 2);
        if (m_rem == 1) begin
          m_dig = p_dig;
          m_ovf = p_ovf;
        end
        if (m_rem > 0) m_rem--;
        if (acc) begin
          if (dec) begin
            v  = value;
            pw = 1;
            for (int i = 0; i < 8; i++) begin
              p_dig[i] = 4'((v / pw) % 10);
              pw = pw * 10;
            end
            p_ovf = (v > 64'd99999999);
            m_rem = 33;
          end else begin
            for (int i = 0; i < 8; i++) p_dig[i] = value[4*i +: 4];
            p_ovf = 0;
            m_rem = 1;
          end
        end
        exp_q.push_back({an, sg, 1'(m_rem >= 2), 1'(m_ovf)});
        m_cyc++;
      end
    end
  endtask

  // Scoreboard: every out-of-reset cycle, outputs must equal the model's word.
  task automatic compare_loop();
    logic [16:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        if (exp_q.size() == 0) begin
          chk("sb_empty", 32'd0, 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("scoreboard", {15'd0, anodes, segments, busy, overflow}, {15'd0, e});
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_load(input logic [31:0] v, input logic d);
    @(negedge clk);
    value = v;
    dec   = d;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) chk("busy_timeout", 32'(n), 32'd0);
  endtask

  task automatic scan_capture();
    for (int i = 0; i < 8; i++) begin
      cap_seen[i] = 0;
      cap_seg[i]  = 7'h7F;
    end
    cap_busy = 0;
    repeat (8 * RD) begin
      @(negedge clk);
      if (busy) cap_busy = 1;
      for (int i = 0; i < 8; i++) begin
        if (anodes[i] == 1'b0) begin
          cap_seen[i]++;
          cap_seg[i] = segments;
        end
      end
    end
  endtask

  task automatic check_scan(input string tag, input logic [6:0] e [8]);
    scan_capture();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_seg%0d", tag, i), 32'(cap_seg[i]), 32'(e[i]));
      chk($sformatf("%s_slot%0d", tag, i), 32'(cap_seen[i]), 32'(RD));
    end
  endtask

  // ---------------- main ----------------
  initial begin
    int n;
    logic [31:0] rv;
    reset = 1'b1;
    value = '0;
    load = 1'b0;
    dec = 1'b0;
    blank_lz = 1'b0;
    fork
      model_loop();
      compare_loop();
    join_none

    repeat (3) @(negedge clk);
    chk("rst_anodes", 32'(anodes), 32'hFF);
    chk("rst_segments", 32'(segments), 32'h7F);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("first_anodes", 32'(anodes), 32'hFE);
    chk("first_segments", 32'(segments), 32'h40);

    // Hex display
    do_load(32'h1234ABCD, 1'b0);
    chk("hex_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    check_scan("hex", hex_exp);
    chk("hex_busy_scan", 32'(cap_busy), 32'd0);

    // Decimal display
    do_load(32'd12345678, 1'b1);
    chk("dec_state", 32'(dbg_state), 32'd1);
    wait_idle(n);
    chk("dec_busy_cycles", 32'(n), 32'd32);
    repeat (2) @(negedge clk);
    check_scan("dec", dec_exp);
    chk("dec_overflow", 32'(overflow), 32'd0);

    // Overflow shows dashes, never blanked
    blank_lz = 1'b1;
    do_load(32'd100000000, 1'b1);
    wait_idle(n);
    repeat (2) @(negedge clk);
    chk("ovf_flag", 32'(overflow), 32'd1);
    check_scan("ovf", dash_exp);

    // Leading-zero blanking
    do_load(32'h00000042, 1'b0);
    repeat (2) @(negedge clk);
    scan_capture();
    chk("blank_d0", 32'(cap_seg[0]), 32'h24);
    chk("blank_d1", 32'(cap_seg[1]), 32'h19);
    for (int i = 2; i < 8; i++) chk($sformatf("blank_seen%0d", i), 32'(cap_seen[i]), 32'd0);
    do_load(32'h0, 1'b0);
    repeat (2) @(negedge clk);
    scan_capture();
    chk("zero_d0", 32'(cap_seg[0]), 32'h40);
    chk("zero_d0_slot", 32'(cap_seen[0]), 32'(RD));
    chk("zero_d7_slot", 32'(cap_seen[7]), 32'd0);
    blank_lz = 1'b0;

    // Collision: second load during conversion is dropped
    do_load(32'd12345678, 1'b1);
    repeat (5) @(negedge clk);
    do_load(32'd99, 1'b1);
    wait_idle(n);
    repeat (2) @(negedge clk);
    check_scan("coll", dec_exp);

    // Reset in the middle of a conversion
    do_load(32'd55555555, 1'b1);
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("mid_rst_anodes", 32'(anodes), 32'hFF);
    chk("mid_rst_segments", 32'(segments), 32'h7F);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_overflow", 32'(overflow), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    check_scan("post_rst", zero_exp);

    // Randomized traffic, checked every cycle by the scoreboard
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 4))
        0:       rv = $urandom;
        1:       rv = $urandom_range(0, 255);
        2:       rv = 32'd99999999;
        3:       rv = 32'd100000000;
        default: rv = $urandom_range(0, 99999999);
      endcase
      @(negedge clk);
      value    = rv;
      dec      = 1'($urandom_range(0, 1));
      blank_lz = 1'($urandom_range(0, 1));
      load     = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      load = 1'b0;
      repeat ($urandom_range(0, 45)) @(negedge clk);
    end
    repeat (50) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
